// File: rtl/patdet_pkg.sv
// Shared constants and helpers for the run-time-loadable pattern sequence detector.
package patdet_pkg;

    localparam int MODE_STICKY  = 1;
    localparam int MODE_REARM   = 0;

    localparam int DEF_SYM_W    = 2;
    localparam int DEF_PAT_LEN  = 3;
    localparam int DEF_IDLE_SYM = 0;

    // Progress counts 0..PAT_LEN inclusive, so it needs room for PAT_LEN+1 values.
    function automatic int patdet_pw(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/patdet_step.sv
// Combinational next-progress function of the pattern detector: given the
// current progress, the incoming symbol and the loaded pattern, pick the next progress.
module patdet_step
    import patdet_pkg::*;
#(
    parameter int SYM_W    = DEF_SYM_W,
    parameter int PAT_LEN  = DEF_PAT_LEN,
    parameter int IDLE_SYM = DEF_IDLE_SYM,
    localparam int PW      = patdet_pw(PAT_LEN)
) (
    input  logic [PW-1:0]            p,
    input  logic [SYM_W-1:0]         in_sym,
    input  logic [PAT_LEN*SYM_W-1:0] pat_q,
    output logic [PW-1:0]            p_next,
    output logic                     hit
);

    localparam logic [SYM_W-1:0] IDLE_V = SYM_W'(IDLE_SYM);

    logic [SYM_W-1:0] cur_sym;
    logic [SYM_W-1:0] prev_sym;
    logic [SYM_W-1:0] first_sym;
    logic             armed;

    // Select pat_q[p] and pat_q[p-1] with constant slices so that p==PAT_LEN
    // (the completed sticky state) never indexes past the pattern.
    always_comb begin
        cur_sym   = '0;
        prev_sym  = '0;
        first_sym = pat_q[SYM_W-1:0];
        for (int i = 0; i < PAT_LEN; i++) begin
            if (PW'(i) == p)
                cur_sym = pat_q[i*SYM_W +: SYM_W];
            if (PW'(i + 1) == p)
                prev_sym = pat_q[i*SYM_W +: SYM_W];
        end
    end

    assign armed = (p < PW'(PAT_LEN));

    always_comb begin
        p_next = p;
        if (armed) begin
            if (in_sym == cur_sym)
                p_next = p + PW'(1);
            else if (in_sym == IDLE_V)
                p_next = p;
            else if ((p != '0) && (in_sym == prev_sym))
                p_next = p;
            else if (in_sym == first_sym)
                p_next = PW'(1);
            else
                p_next = '0;
        end
    end

    assign hit = armed && (p_next == PW'(PAT_LEN));

endmodule

// File: rtl/pattern_seq_detector.sv
// Valid-qualified stream monitor that detects a run-time-loadable pattern in
// sticky or re-arming mode. Optional saturating match counter under PATDET_COUNT_EN.
module pattern_seq_detector
    import patdet_pkg::*;
#(
    parameter int SYM_W    = DEF_SYM_W,
    parameter int PAT_LEN  = DEF_PAT_LEN,
    parameter int IDLE_SYM = DEF_IDLE_SYM,
    parameter int STICKY   = MODE_STICKY,
    parameter int CNT_W    = 8,
    localparam int PW      = patdet_pw(PAT_LEN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_load,
    input  logic [PAT_LEN*SYM_W-1:0] pattern,
    input  logic                     in_valid,
    input  logic [SYM_W-1:0]         in_sym,
    output logic [PW-1:0]            progress,
    output logic                     match_pulse,
    output logic                     ans
`ifdef PATDET_COUNT_EN
    ,
    output logic [CNT_W-1:0]         match_cnt
`endif
);

    localparam bit STICKY_MODE = (STICKY == MODE_STICKY);

    if (SYM_W < 1 || SYM_W > 8 || PAT_LEN < 2 || PAT_LEN > 16 || CNT_W < 1 ||
        (STICKY != MODE_STICKY && STICKY != MODE_REARM)) begin : g_bad_cfg
        $error("pattern_seq_detector: unsupported parameter combination");
    end

    logic [PAT_LEN*SYM_W-1:0] pat_q;
    logic [PW-1:0]            p_next;
    logic                     hit;

    patdet_step #(
        .SYM_W    (SYM_W),
        .PAT_LEN  (PAT_LEN),
        .IDLE_SYM (IDLE_SYM)
    ) u_step (
        .p      (progress),
        .in_sym (in_sym),
        .pat_q  (pat_q),
        .p_next (p_next),
        .hit    (hit)
    );

    // Priority: cfg_load, then a valid symbol, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q       <= '0;
            progress    <= '0;
            match_pulse <= 1'b0;
            ans         <= 1'b0;
        end else if (cfg_load) begin
            pat_q       <= pattern;
            progress    <= '0;
            match_pulse <= 1'b0;
            ans         <= 1'b0;
        end else if (in_valid) begin
            match_pulse <= hit;
            if (hit) begin
                progress <= STICKY_MODE ? PW'(PAT_LEN) : '0;
                ans      <= 1'b1;
            end else begin
                progress <= p_next;
                if (!STICKY_MODE)
                    ans <= 1'b0;
            end
        end else begin
            match_pulse <= 1'b0;
            if (!STICKY_MODE)
                ans <= 1'b0;
        end
    end

`ifdef PATDET_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating; sticky mode can only ever reach 1 because hit cannot recur.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            match_cnt <= '0;
        else if (cfg_load)
            match_cnt <= '0;
        else if (in_valid && hit && (match_cnt != CNT_MAX))
            match_cnt <= match_cnt + CNT_W'(1);
    end
`endif

endmodule
